// File: rtl/riscv_mmio_uart_tx_if.sv
// Data-memory bus slice seen by riscv_mmio_uart_tx.
//   i_cs        : access targets the UART this cycle
//   i_wr_en     : store strobe (valid only with i_cs)
//   i_byte_sel  : store byte enables, lane0 = bits[7:0]
//   i_addr      : byte offset, bits[1:0] ignored
//   i_wdata     : store data
//   o_rdata     : load data, combinational
interface riscv_mmio_uart_tx_if #(
    parameter int unsigned ADDR_BIT = 4
) ();
    logic                i_cs;
    logic                i_wr_en;
    logic [3:0]          i_byte_sel;
    logic [ADDR_BIT-1:0] i_addr;
    logic [31:0]         i_wdata;
    logic [31:0]         o_rdata;

    modport master (output i_cs, i_wr_en, i_byte_sel, i_addr, i_wdata, input o_rdata);
    modport slave  (input i_cs, i_wr_en, i_byte_sel, i_addr, i_wdata, output o_rdata);
endinterface

// File: rtl/riscv_mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a TX FIFO.
// Ports:
//   i_clk, i_rst : clock, asynchronous active-high reset
//   bus          : riscv_mmio_uart_tx_if.slave register access
//   o_txd        : serial output, idle high (registered)
//   o_irq        : level irq, FIFO empty and transmitter idle with irq_en (registered)
// Registers: 0x0 TXDATA(W), 0x4 STATUS(R), 0x8 BAUDDIV(RW), 0xC CTRL(RW).
// Optional macro UART_PARITY_EN adds a parity bit (CTRL bit3 selects odd).
module riscv_mmio_uart_tx #(
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd867,
    parameter int unsigned ADDR_BIT    = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    riscv_mmio_uart_tx_if.slave  bus,
    output logic                 o_txd,
    output logic                 o_irq
);
    localparam int unsigned IDX_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned PTR_W  = IDX_W + 1;
    localparam int unsigned WORD_W = ADDR_BIT - 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t             state_q, state_d;
    logic [15:0]        baud_q, baud_d;
    logic [2:0]         bit_q, bit_d;
    logic [7:0]         shift_q, shift_d;
    logic [15:0]        div_q, div_d;
    logic               tx_en_q, tx_en_d;
    logic               irq_en_q, irq_en_d;
    logic               ovf_q, ovf_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic               txd_q, txd_d;
    logic               irq_q, irq_d;
    logic               odd_q, odd_d;
    logic               par_q, par_d;
    logic [7:0]         mem [FIFO_DEPTH];

    // Address decode on word offset
    logic [WORD_W-1:0]  word;
    logic               wr_acc, wr_txdata, wr_div, wr_ctrl;
    logic               empty, full, push, pop;
    logic [PTR_W-1:0]   count;
    logic [7:0]         head;

    assign word      = bus.i_addr[ADDR_BIT-1:2];
    assign wr_acc    = bus.i_cs & bus.i_wr_en;
    assign wr_txdata = wr_acc & (word == WORD_W'(0)) & bus.i_byte_sel[0];
    assign wr_div    = wr_acc & (word == WORD_W'(2)) & (bus.i_byte_sel[1:0] == 2'b11);
    assign wr_ctrl   = wr_acc & (word == WORD_W'(3)) & bus.i_byte_sel[0];

    // Extra pointer MSB distinguishes full from empty
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                   (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
    assign count = wr_ptr_q - rd_ptr_q;
    assign head  = mem[rd_ptr_q[IDX_W-1:0]];
    // A push into a full FIFO is dropped even if a pop happens this cycle
    assign push  = wr_txdata & ~full;
    assign pop   = (state_q == S_IDLE) & tx_en_q & ~empty;

    logic unused_bits;
    assign unused_bits = ^{bus.i_wdata[31:16], bus.i_byte_sel[3:2], bus.i_addr[1:0]};

    // FIFO storage
    always_ff @(posedge i_clk) begin
        if (push) mem[wr_ptr_q[IDX_W-1:0]] <= bus.i_wdata[7:0];
    end

    // State and register update
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            baud_q   <= 16'd0;
            bit_q    <= 3'd0;
            shift_q  <= 8'd0;
            div_q    <= DEFAULT_DIV;
            tx_en_q  <= 1'b0;
            irq_en_q <= 1'b0;
            ovf_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            txd_q    <= 1'b1;
            irq_q    <= 1'b0;
            odd_q    <= 1'b0;
            par_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            div_q    <= div_d;
            tx_en_q  <= tx_en_d;
            irq_en_q <= irq_en_d;
            ovf_q    <= ovf_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            txd_q    <= txd_d;
            irq_q    <= irq_d;
            odd_q    <= odd_d;
            par_q    <= par_d;
        end
    end

    // Next-state: transmit FSM, FIFO pointers, register writes
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        div_d    = div_q;
        tx_en_d  = tx_en_q;
        irq_en_d = irq_en_q;
        ovf_d    = ovf_q;
        odd_d    = odd_q;
        par_d    = par_q;
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);

        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    shift_d = head;
                    par_d   = ^head;
                    baud_d  = div_q;
                    bit_d   = 3'd0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (baud_q == 16'd0) begin
                    baud_d  = div_q;
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            S_DATA: begin
                if (baud_q == 16'd0) begin
                    baud_d  = div_q;
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
`ifdef UART_PARITY_EN
            S_PARITY: begin
                if (baud_q == 16'd0) begin
                    baud_d  = div_q;
                    state_d = S_STOP;
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
`endif
            S_STOP: begin
                if (baud_q == 16'd0) begin
                    state_d = S_IDLE;
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (wr_txdata && full) ovf_d = 1'b1;
        if (wr_div) div_d = bus.i_wdata[15:0];
        if (wr_ctrl) begin
            tx_en_d  = bus.i_wdata[0];
            irq_en_d = bus.i_wdata[1];
`ifdef UART_PARITY_EN
            odd_d    = bus.i_wdata[3];
`endif
            if (bus.i_wdata[2]) ovf_d = 1'b0;
        end

        // Line level follows the current state one cycle later
        case (state_q)
            S_START:  txd_d = 1'b0;
            S_DATA:   txd_d = shift_q[0];
`ifdef UART_PARITY_EN
            S_PARITY: txd_d = par_q ^ odd_q;
`endif
            default:  txd_d = 1'b1;
        endcase
        irq_d = irq_en_q & empty & (state_q == S_IDLE);
    end

    // Load data
    always_comb begin
        bus.o_rdata = 32'd0;
        if (bus.i_cs) begin
            case (word)
                WORD_W'(1): bus.o_rdata = {20'd0, 4'(count), 4'd0, ovf_q, empty, full,
                                           (state_q != S_IDLE)};
                WORD_W'(2): bus.o_rdata = {16'd0, div_q};
                WORD_W'(3): bus.o_rdata = {28'd0, odd_q, 1'b0, irq_en_q, tx_en_q};
                default:    bus.o_rdata = 32'd0;
            endcase
        end
    end

    assign o_txd = txd_q;
    assign o_irq = irq_q;
endmodule

// File: doc/riscv_mmio_uart_tx.md
Name: riscv_mmio_uart_tx

Overview:
- Memory-mapped UART transmitter that sits on the CPU data-memory bus as a responder, beside riscv_dmem.
- Memory-stage stores push bytes into a TX FIFO; loads read status and config registers.
- A baud-rate FSM serialises each byte as 8N1 on o_txd.
- The top-level address decode drives i_cs. The block sees only word offsets.

Parameters:
- FIFO_DEPTH, 8, TX FIFO entries; must be a power of 2, minimum 2.
- DEFAULT_DIV, 16'd867, BAUDDIV reset value (100 MHz / 115200 − 1).
- ADDR_BIT, 4, width of i_addr byte offset.

Ports:
- i_clk  input  1  system clock.
- i_rst  input  1  asynchronous active-high reset.
- i_cs  input  1  bus access targets this block this cycle.
- i_wr_en  input  1  store strobe (valid only with i_cs).
- i_byte_sel  input  4  store byte enables, lane0 = bits[7:0].
- i_addr  input  ADDR_BIT  byte offset; bits[1:0] ignored.
- i_wdata  input  32  store data.
- o_rdata  output  32  load data, combinational from i_addr and registers.
- o_txd  output  1  serial output, idle high.
- o_irq  output  1  level: FIFO empty and transmitter idle while CTRL.irq_en=1.

Behaviour:
Register map (word offsets); every write needs i_cs & i_wr_en:
- 0x0 TXDATA, write-only. A write with i_byte_sel[0]=1 pushes i_wdata[7:0]. If the FIFO is full, the byte is dropped and STATUS.ovf is set. Reads return 0.
- 0x4 STATUS, read-only. bit0 busy (FSM not IDLE), bit1 full, bit2 empty, bit3 ovf (sticky), bits[11:8] FIFO count (zero-extended), other bits 0.
- 0x8 BAUDDIV, R/W. Bits[15:0] are written when i_byte_sel[1:0]=2'b11; other byte-select combinations are ignored. Bit period = BAUDDIV+1 cycles. A write takes effect at the next bit boundary.
- 0xC CTRL, R/W. bit0 tx_en, bit1 irq_en. bit2 is write-1-to-clear ovf and always reads 0. Written only when i_byte_sel[0]=1.
- Reads with i_cs=0 return 32'h0. Reads have no side effects.

Reset (async, i_rst=1):
- o_txd=1, o_irq=0.
- FIFO empty, pointers 0, ovf=0.
- BAUDDIV=DEFAULT_DIV, CTRL=0, FSM=IDLE.
- A reset mid-frame aborts the frame immediately; o_txd returns to 1.

FIFO:
- Circular buffer with log2(FIFO_DEPTH)+1-bit pointers.
- full = pointer MSBs differ and lower bits equal.
- A push and a pop in the same cycle are both performed; count is unchanged.
- A push when full is dropped, even if a pop occurs in the same cycle. This keeps the logic simple and is a documented limitation.

FSM states: IDLE, START, DATA, STOP.
- IDLE: o_txd=1. If tx_en and not empty, pop the head into the shift register, load the baud counter, and go to START on the next cycle.
- START: o_txd=0 for one bit period.
- DATA: shift LSB first, 8 bits, tracked by a 3-bit bit counter.
- STOP: o_txd=1 for one bit period, then IDLE.
- Back-to-back frames: IDLE lasts exactly one cycle between the STOP end and the next START.
- Baud counter: counts down from BAUDDIV to 0; at 0 it advances the bit and reloads BAUDDIV.
- Clearing tx_en mid-frame lets the current frame finish; no new pop follows.
- BAUDDIV=0 is legal: one cycle per bit.
- First START edge occurs 2 cycles after the TXDATA store clock edge when idle and tx_en=1.

Optional Feature:
- Macro UART_PARITY_EN.
- Defined: adds FSM state PARITY between DATA and STOP, sending an even-parity bit (XOR of the 8 data bits) for one bit period. CTRL bit3 = odd-parity select (R/W); when set, the bit is inverted. Frame = 11 bit periods.
- Undefined: no PARITY state, CTRL bit3 reads 0, frame = 10 bit periods.

Test Plan:
1. Reset, write BAUDDIV=3 (byte_sel 4'b0011), CTRL=1, TXDATA=8'hA5 -> o_txd low for 4 cycles, then 1,0,1,0,0,1,0,1 at 4 cycles each, then high for 4 cycles. STATUS busy=1 during the frame and 0 after.
2. With tx_en=0, write 9 bytes 0x01..0x09 (FIFO_DEPTH=8) -> STATUS=0x0000_080A (count 8, full, ovf); 0x09 is absent. Write CTRL=5 -> ovf clears and transmission of 0x01..0x08 starts in order.
3. Back-to-back: BAUDDIV=0, push 0x00 and 0xFF -> frames are contiguous with exactly 1 idle-high cycle between them. o_irq (irq_en=1) asserts only after the second stop bit.
4. Simultaneous push/pop: push during the IDLE→START pop cycle with count=1 -> count stays 1 and the new byte is sent next.
5. Assert i_rst during the DATA bit 3 of 0x3C -> o_txd=1 immediately; STATUS reads 0x0000_0004, BAUDDIV reads 867, CTRL reads 0.
6. UART_PARITY_EN defined, byte 0x07 -> parity bit 1; with CTRL bit3=1 -> parity bit 0; frame is 11 bit periods.
